// File: rtl/button_conditioner_if.sv
// Bundles the raw button pins and the conditioned level/strobe outputs of button_conditioner.
interface button_conditioner_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] buttons_n;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] repeat_pulse;
    logic             any_pressed;

    modport master (
        output buttons_n,
        input  pressed, press_pulse, release_pulse, repeat_pulse, any_pressed
    );

    modport slave (
        input  buttons_n,
        output pressed, press_pulse, release_pulse, repeat_pulse, any_pressed
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and press/release/auto-repeat strobe generator.
module button_conditioner #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000
) (
    input  logic                 clk_27M,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rstate_t;

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] r_pressed;
    logic [WIDTH-1:0] r_press_pulse;
    logic [WIDTH-1:0] r_release_pulse;
    logic [WIDTH-1:0] r_repeat_pulse;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_press_evt;
    logic [WIDTH-1:0] w_release_evt;
    logic [WIDTH-1:0] w_repeat_fire;

    // The inverted sample is registered, so pressed moves DEBOUNCE_CYCLES+2
    // edges after the first edge that sees the new pin level.
    always_ff @(posedge clk_27M or negedge rst_n) begin
        if (!rst_n) begin
            r_meta          <= '1;
            r_sync          <= '1;
            r_sample        <= '0;
            r_pressed       <= '0;
            r_press_pulse   <= '0;
            r_release_pulse <= '0;
            r_repeat_pulse  <= '0;
        end else begin
            r_meta          <= bus.buttons_n;
            r_sync          <= r_meta;
            r_sample        <= ~r_sync;
            r_pressed       <= r_pressed ^ w_toggle;
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
            r_repeat_pulse  <= w_repeat_fire;
        end
    end

    assign w_press_evt   = w_toggle & r_sample;
    assign w_release_evt = w_toggle & ~r_sample;

    assign bus.pressed       = r_pressed;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.repeat_pulse  = r_repeat_pulse;
    assign bus.any_pressed   = |r_pressed;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] r_cnt;
            logic          w_diff;
            rstate_t       r_state;
            rstate_t       w_state_next;
            logic [31:0]   r_rcnt;
            logic [31:0]   w_rcnt_next;
            logic          w_fire;

            assign w_diff        = r_sample[gi] != r_pressed[gi];
            assign w_toggle[gi]  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
            assign w_repeat_fire[gi] = w_fire;

            // Any return to the stable level restarts the debounce window.
            always_ff @(posedge clk_27M or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!w_diff || w_toggle[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            always_ff @(posedge clk_27M or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_rcnt  <= w_rcnt_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_rcnt_next  = r_rcnt;
                case (r_state)
                    S_IDLE: begin
                        if (w_press_evt[gi] && (REPEAT_DELAY != 0)) begin
                            w_state_next = S_DELAY;
                            w_rcnt_next  = '0;
                        end
                    end
                    S_DELAY: begin
                        if (w_release_evt[gi]) begin
                            w_state_next = S_IDLE;
                            w_rcnt_next  = '0;
                        end else if (r_rcnt == 32'(REPEAT_DELAY - 1)) begin
                            w_state_next = S_REPEAT;
                            w_rcnt_next  = '0;
                        end else begin
                            w_rcnt_next  = r_rcnt + 32'd1;
                        end
                    end
                    S_REPEAT: begin
                        if (w_release_evt[gi]) begin
                            w_state_next = S_IDLE;
                            w_rcnt_next  = '0;
                        end else if (r_rcnt == 32'(REPEAT_PERIOD - 1)) begin
                            w_rcnt_next  = '0;
                        end else begin
                            w_rcnt_next  = r_rcnt + 32'd1;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_rcnt_next  = '0;
                    end
                endcase
            end

            // A release on the same edge wins, so no strobe escapes after letting go.
            always_comb begin
                w_fire = 1'b0;
                case (r_state)
                    S_DELAY:  w_fire = !w_release_evt[gi] && (r_rcnt == 32'(REPEAT_DELAY - 1));
                    S_REPEAT: w_fire = !w_release_evt[gi] && (r_rcnt == 32'(REPEAT_PERIOD - 1));
                    default:  w_fire = 1'b0;
                endcase
            end
        end
    endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: expected strobes are queued when a hold is driven and matched per cycle.
module tb_button_conditioner;
    localparam int W  = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    typedef struct {
        int cyc;
        int kind;
        int b;
    } ev_t;

    typedef struct {
        logic [W-1:0] mask;
        int hold;
        int idle;
        int reps;
        int accept;
        int nrep;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    button_conditioner_if #(.WIDTH(W)) bus();

    button_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_27M(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    ev_t          q[$];
    int           cyc = 0;
    int           rel_at[W];
    logic [W-1:0] exp_pressed = '0;
    int           n_vec = 0;
    int           n_bad = 0;
    vec_t         tbl[7];

    task automatic compare(input string name, input logic [W-1:0] ep, input logic [W-1:0] epp,
                           input logic [W-1:0] erl, input logic [W-1:0] erp);
        logic ea;
        ea = |ep;
        n_vec++;
        if (bus.pressed !== ep || bus.press_pulse !== epp || bus.release_pulse !== erl ||
            bus.repeat_pulse !== erp || bus.any_pressed !== ea) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got pressed=%b press=%b rel=%b rep=%b any=%b, want pressed=%b press=%b rel=%b rep=%b any=%b",
                     name, cyc, bus.pressed, bus.press_pulse, bus.release_pulse, bus.repeat_pulse,
                     bus.any_pressed, ep, epp, erl, erp, ea);
        end
    endtask

    task automatic check_cycle();
        logic [W-1:0] epp, erl, erp;
        epp = '0; erl = '0; erp = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    K_PRESS: epp[q[i].b] = 1'b1;
                    K_REL:   erl[q[i].b] = 1'b1;
                    default: erp[q[i].b] = 1'b1;
                endcase
                q.delete(i);
            end
        end
        exp_pressed = (exp_pressed | epp) & ~erl;
        compare("cycle", exp_pressed, epp, erl, erp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        for (int b = 0; b < W; b++) begin
            if (rel_at[b] == cyc) begin
                bus.buttons_n[b] = 1'b1;
                rel_at[b] = -1;
            end
        end
    endtask

    // A pin driven low after edge 'start' is accepted at edge start+D+3.
    task automatic push_hold(input int b, input int start, input int hold, input int accept, input int nrep);
        if (accept != 0) begin
            q.push_back('{start + D + 3, K_PRESS, b});
            q.push_back('{start + hold + D + 3, K_REL, b});
            for (int k = 0; k < nrep; k++)
                q.push_back('{start + D + 3 + RD + RP * k, K_REP, b});
        end
    endtask

    task automatic start_hold(input int b, input int hold, input int accept, input int nrep);
        bus.buttons_n[b] = 1'b0;
        rel_at[b] = cyc + hold;
        push_hold(b, cyc, hold, accept, nrep);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // mask, hold, idle, reps, accept, expected repeat count
        tbl[0] = '{5'b00001,  6, 10, 1, 1, 0};
        tbl[1] = '{5'b00100,  3,  3, 5, 0, 0};
        tbl[2] = '{5'b00010, 30, 10, 1, 1, 7};
        tbl[3] = '{5'b00001,  4, 10, 1, 1, 0};
        tbl[4] = '{5'b00001, 10, 10, 1, 1, 0};
        tbl[5] = '{5'b00001, 11, 10, 1, 1, 1};
        tbl[6] = '{5'b10100, 13, 10, 1, 1, 1};
        for (int b = 0; b < W; b++) rel_at[b] = -1;

        bus.buttons_n = 5'b10110;
        #1 rst_n = 1'b0;
        #1 compare("reset_pre_clock", '0, '0, '0, '0);
        repeat (2) tick();
        bus.buttons_n = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 7; i++) begin
            $display("vector %0d: mask=%b hold=%0d reps=%0d", i, tbl[i].mask, tbl[i].hold, tbl[i].reps);
            for (int r = 0; r < tbl[i].reps; r++) begin
                for (int b = 0; b < W; b++)
                    if (tbl[i].mask[b]) start_hold(b, tbl[i].hold, tbl[i].accept, tbl[i].nrep);
                repeat (tbl[i].hold + tbl[i].idle) tick();
            end
        end

        $display("sequence: bits 3 and 4 pressed together, bit 3 released during bit 4 delay");
        start_hold(3, 8, 1, 0);
        start_hold(4, 25, 1, 5);
        repeat (40) tick();

        $display("sequence: reset while bit 0 is auto-repeating");
        start_hold(0, 40, 1, 2);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_pressed = '0;
        compare("reset_mid_hold", '0, '0, '0, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        push_hold(0, cyc, rel_at[0] - cyc, 1, 3);
        repeat (40) tick();

        for (int t = 0; t < 100 && q.size() > 0; t++) tick();
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected events, want 0", q.size());
        end
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
